// File: rtl/div_share_ctrl.sv
// Round-robin arbiter and hold-valid sequencer for one shared iterative divider.
// Optional macro DIV_SHARE_CTRL_ZERO_BYPASS_EN answers zero divisors without the divider.
module div_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_dividend_i,
  input  logic [WIDTH-1:0] req0_divisor_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_dividend_i,
  input  logic [WIDTH-1:0] req1_divisor_i,
  output logic             rsp0_valid_o,
  output logic [WIDTH-1:0] rsp0_data_o,
  output logic             rsp0_error_o,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp1_data_o,
  output logic             rsp1_error_o,
  output logic             div_valid_o,
  output logic [2:0]       div_op_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic [WIDTH-1:0] div_data_i,
  input  logic             div_ready_i,
  input  logic             div_error_i,
  output logic             busy_o
);

  // state  | meaning
  // S_IDLE | arbitrate, accept one request
  // S_WAIT | divider running with valid held; timeout down-counter active
  // S_RESP | one-cycle response to the latched port, divider valid dropped
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           r_state, w_state_nxt;
  logic             r_prio;
  logic             r_port;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_dividend, r_divisor;
  logic [CW-1:0]    r_cnt;
  logic             r_div_valid, r_busy;
  logic             r_rsp0_valid, r_rsp1_valid, r_rsp0_err, r_rsp1_err;
  logic [WIDTH-1:0] r_rsp0_data, r_rsp1_data;

  logic             w_grant0, w_grant1, w_hs, w_rsp_port, w_enter_resp;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_dividend, w_sel_divisor, w_res;
  logic             w_err;

  // r_prio names the port that wins when both request
  assign w_grant1       = req1_valid_i & (~req0_valid_i | r_prio);
  assign w_grant0       = req0_valid_i & ~w_grant1;
  assign req0_ready_o   = (r_state == S_IDLE) & w_grant0;
  assign req1_ready_o   = (r_state == S_IDLE) & w_grant1;
  assign w_hs           = (r_state == S_IDLE) & (req0_valid_i | req1_valid_i);
  assign w_sel_op       = w_grant1 ? req1_op_i       : req0_op_i;
  assign w_sel_dividend = w_grant1 ? req1_dividend_i : req0_dividend_i;
  assign w_sel_divisor  = w_grant1 ? req1_divisor_i  : req0_divisor_i;
  assign w_rsp_port     = (r_state == S_IDLE) ? w_grant1 : r_port;
  assign w_enter_resp   = (w_state_nxt == S_RESP) & (r_state != S_RESP);

  always_comb begin
    w_state_nxt = r_state;
    w_res       = '0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_nxt = S_WAIT;
`ifdef DIV_SHARE_CTRL_ZERO_BYPASS_EN
          if (w_sel_divisor == '0) begin
            w_state_nxt = S_RESP;
            w_err       = 1'b1;
            w_res       = w_sel_op[1] ? w_sel_dividend : '1;
          end
`endif
        end
      end
      S_WAIT: begin
        // divider completion takes precedence over a coincident timeout
        if (div_ready_i) begin
          w_state_nxt = S_RESP;
          w_err       = div_error_i;
          w_res       = div_error_i ? (r_op[1] ? r_dividend : '1) : div_data_i;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_err       = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_prio       <= 1'b0;
      r_port       <= 1'b0;
      r_op         <= '0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_cnt        <= '0;
      r_div_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_valid <= (w_state_nxt == S_WAIT);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_hs) begin
        r_port     <= w_grant1;
        r_op       <= w_sel_op;
        r_dividend <= w_sel_dividend;
        r_divisor  <= w_sel_divisor;
        r_cnt      <= CW'(TIMEOUT - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_rsp0_valid <= w_enter_resp & ~w_rsp_port;
      r_rsp1_valid <= w_enter_resp & w_rsp_port;
      if (w_enter_resp && !w_rsp_port) begin
        r_rsp0_data <= w_res;
        r_rsp0_err  <= w_err;
      end
      if (w_enter_resp && w_rsp_port) begin
        r_rsp1_data <= w_res;
        r_rsp1_err  <= w_err;
      end
      if (r_state == S_RESP) r_prio <= ~r_port;
    end
  end

  assign div_valid_o    = r_div_valid;
  assign div_op_o       = r_op;
  assign div_dividend_o = r_dividend;
  assign div_divisor_o  = r_divisor;
  assign busy_o         = r_busy;
  assign rsp0_valid_o   = r_rsp0_valid;
  assign rsp0_data_o    = r_rsp0_data;
  assign rsp0_error_o   = r_rsp0_err;
  assign rsp1_valid_o   = r_rsp1_valid;
  assign rsp1_data_o    = r_rsp1_data;
  assign rsp1_error_o   = r_rsp1_err;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Randomised bench for div_share_ctrl with a 35-cycle divider model and a RISC-V division reference.
module tb_div_share_ctrl;
  localparam int TIMEOUT = 64;
`ifdef DIV_SHARE_CTRL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  ready;
  logic [2:0]  op0 = 3'd4, op1 = 3'd4;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  rsp_valid, rsp_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic        div_valid_o, busy_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_dividend_o, div_divisor_o;
  logic [31:0] dv_data = '0;
  logic        dv_ready = 1'b0, dv_error = 1'b0;
  bit          dv_hang = 1'b0;
  int          dcnt = 0;
  int          cyc_n = 0, n_chk = 0, n_pass = 0;
  bit          m_prio = 1'b0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  div_share_ctrl #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_valid_i(req_valid[0]), .req0_ready_o(ready[0]), .req0_op_i(op0),
    .req0_dividend_i(a0), .req0_divisor_i(b0),
    .req1_valid_i(req_valid[1]), .req1_ready_o(ready[1]), .req1_op_i(op1),
    .req1_dividend_i(a1), .req1_divisor_i(b1),
    .rsp0_valid_o(rsp_valid[0]), .rsp0_data_o(rsp0_data), .rsp0_error_o(rsp_err[0]),
    .rsp1_valid_o(rsp_valid[1]), .rsp1_data_o(rsp1_data), .rsp1_error_o(rsp_err[1]),
    .div_valid_o(div_valid_o), .div_op_o(div_op_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_data_i(dv_data), .div_ready_i(dv_ready), .div_error_i(dv_error),
    .busy_o(busy_o)
  );

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      3'b100:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'b101:  return a / b;
      3'b110:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // divider: ready in the 35th cycle of valid (3rd for a zero divisor), garbage data on error
  always @(negedge clk_i) begin
    if (div_valid_o && !dv_hang) begin
      dcnt     <= dcnt + 1;
      dv_ready <= (dcnt + 1 == ((div_divisor_o == 0) ? 3 : 35));
      dv_error <= (div_divisor_o == 0);
      dv_data  <= (div_divisor_o == 0) ? 32'hDEAD_BEEF : ref_div(div_op_o, div_dividend_o, div_divisor_o);
    end else begin
      dcnt     <= 0;
      dv_ready <= 1'b0;
      dv_error <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
  endtask

  task automatic transact(input bit v0, input bit v1,
                          input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                          input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                          input string tag);
    bit win, exp_e, saw_dv, bad_ops, bad_rdy, bad_busy;
    logic [2:0] op;
    logic [31:0] a, b, exp_d, got_d;
    int exp_lat, lat, n;
    win = (v0 && v1) ? m_prio : v1;
    op = win ? o1 : o0; a = win ? x1 : x0; b = win ? y1 : y0;
    if (dv_hang && !(BYP && b == 0)) begin
      exp_d = 0; exp_e = 1'b1; exp_lat = TIMEOUT + 1;
    end else begin
      exp_d = ref_div(op, a, b); exp_e = (b == 0);
      exp_lat = (b != 0) ? 36 : (BYP ? 1 : 4);
    end
    @(posedge clk_i); #1;
    req_valid = {v1, v0};
    op0 = o0; a0 = x0; b0 = y0; op1 = o1; a1 = x1; b1 = y1;
    #1;
    n = 0;
    while (ready == 2'b00 && n < 10) begin @(posedge clk_i); #2; n++; end
    chk({tag, "_grant"}, 32'(ready), win ? 32'd2 : 32'd1);
    @(posedge clk_i); #1;
    m_prio = ~win;
    req_valid = 2'($urandom);
    op0 = 3'($urandom_range(4, 7)); op1 = 3'($urandom_range(4, 7));
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    #1;
    lat = 1; saw_dv = 0; bad_ops = 0; bad_rdy = 0; bad_busy = 0;
    while (rsp_valid == 2'b00 && lat < TIMEOUT + 20) begin
      if (div_valid_o) begin
        saw_dv = 1;
        if (div_op_o !== op || div_dividend_o !== a || div_divisor_o !== b) bad_ops = 1;
      end
      if (ready != 2'b00) bad_rdy = 1;
      if (!busy_o) bad_busy = 1;
      @(posedge clk_i); #2; lat++;
    end
    req_valid = '0;
    got_d = win ? rsp1_data : rsp0_data;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rsp_port"}, 32'(rsp_valid), win ? 32'd2 : 32'd1);
    chk({tag, "_data"}, got_d, exp_d);
    chk({tag, "_error"}, 32'(rsp_err[win]), 32'(exp_e));
    chk({tag, "_divvalid_in_resp"}, 32'(div_valid_o), 0);
    chk({tag, "_busy_in_resp"}, 32'(busy_o), 1);
    chk({tag, "_ops_stable"}, 32'(bad_ops), 0);
    chk({tag, "_no_ready_busy"}, 32'({bad_rdy, bad_busy}), 0);
    chk({tag, "_div_used"}, 32'(saw_dv), 32'(exp_lat != 1));
    @(posedge clk_i); #2;
    chk({tag, "_pulse_one_cycle"}, 32'({rsp_valid, busy_o}), 0);
    chk({tag, "_data_held"}, win ? rsp1_data : rsp0_data, exp_d);
  endtask

  initial begin
    bit bad;
    #2;
    chk("reset_outputs", {rsp_valid, rsp_err, div_valid_o, busy_o, ready}, 0);
    chk("reset_data", rsp0_data | rsp1_data | div_dividend_o | div_divisor_o | 32'(div_op_o), 0);
    repeat (2) @(posedge clk_i);
    #1; rst_ni = 1'b1;

    transact(1, 1, 3'b111, 32'd100, 32'd7, 3'b101, 32'd100, 32'd7, "tie_first");
    transact(1, 1, 3'b111, 32'd100, 32'd7, 3'b101, 32'd100, 32'd7, "tie_second");
    transact(1, 0, 3'b100, 32'hFFFF_FFEC, 32'd3, 3'b100, 0, 0, "div_neg");
    transact(0, 1, 3'b100, 0, 0, 3'b110, 32'h1234_5678, 32'd0, "rem_by_zero");
    transact(1, 0, 3'b101, 32'd7, 32'd0, 3'b100, 0, 0, "divu_by_zero");
    dv_hang = 1'b1;
    transact(1, 0, 3'b101, 32'd5, 32'd1, 3'b100, 0, 0, "timeout");
    dv_hang = 1'b0;

    // reset in the middle of a port-1 operation; port 0 was served last
    @(posedge clk_i); #1;
    req_valid = 2'b10; op1 = 3'b101; a1 = 32'd99; b1 = 32'd5;
    @(posedge clk_i); #1;
    req_valid = '0;
    repeat (10) @(posedge clk_i);
    #1;
    chk("pre_reset_divvalid", 32'(div_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("midop_reset_outputs", {rsp_valid, rsp_err, div_valid_o, busy_o, ready}, 0);
    chk("midop_reset_data", rsp0_data | rsp1_data | div_dividend_o | div_divisor_o | 32'(div_op_o), 0);
    m_prio = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_ni = 1'b1;
    bad = 0;
    repeat (45) begin @(posedge clk_i); #2; if (rsp_valid != 0 || div_valid_o) bad = 1; end
    chk("no_rsp_after_abort", 32'(bad), 0);
    transact(1, 1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 3'b111, 32'd9, 32'd4, "post_reset_ovf");

    for (int i = 0; i < 16; i++) begin
      int v, sel;
      logic [31:0] x0, y0, x1, y1;
      v = $urandom_range(1, 3);
      x0 = $urandom; x1 = $urandom;
      y0 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
      y1 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) begin x0 = 32'h8000_0000; y0 = 32'hFFFF_FFFF; end
      if (sel == 1) y1 = 0;
      transact(v[0], v[1], 3'($urandom_range(4, 7)), x0, y0,
               3'($urandom_range(4, 7)), x1, y1, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
